axis_width_split: RTL

- Single-clock AXI4-Stream width downsizer: 512-bit input beats become 256-bit output beats, lower half first.
- It is the transmit-side counterpart of the 256-to-512 combiner. It feeds 256-bit consumers from the 512-bit user side of the PCIe loopback.
- It drops an empty upper half on the final beat of a packet. It also counts packets and flags non-contiguous tkeep.

---
 rtl/axis_width_pkg.sv | 22 ++
 rtl/axis_width_split.sv | 111 +++++++++++
 2 files changed

// File: rtl/axis_width_pkg.sv
// Shared definitions for the 512<->256 AXI4-Stream width converters:
// state encodings, width constants and a keep-contiguity helper.
package axis_width_pkg;

  localparam int AXIS_M_DATA_W = 256;
  localparam int AXIS_S_DATA_W = 2 * AXIS_M_DATA_W;
  localparam int AXIS_M_KEEP_W = AXIS_M_DATA_W / 8;
  localparam int AXIS_S_KEEP_W = AXIS_S_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LO    = 2'd1,
    ST_HI    = 2'd2
  } state_e;

  // A keep half is contiguous when its set bits form one run starting at
  // bit 0; adding 1 to such a run clears every bit of it.
  function automatic logic keep_contig(input logic [63:0] keep);
    return ((keep + 64'd1) & keep) == 64'd0;
  endfunction

endpackage

// File: rtl/axis_width_split.sv
// AXI4-Stream 512->256 downsizer: each input beat is emitted as a lower then an
// upper half; an all-empty upper half on a packet's last beat is dropped.
module axis_width_split
  import axis_width_pkg::*;
#(
  parameter int M_DATA_WIDTH = AXIS_M_DATA_W,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                      s_axis_aclk,
  input  logic                      s_axis_aresetn,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [2*M_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [M_DATA_WIDTH/4-1:0] s_axis_tkeep,
  input  logic                      s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [M_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [CNT_WIDTH-1:0]      pkt_cnt,
  output logic                      keep_err
);

  localparam int S_DATA_WIDTH = 2 * M_DATA_WIDTH;
  localparam int M_KEEP_WIDTH = M_DATA_WIDTH / 8;
  localparam int S_KEEP_WIDTH = 2 * M_KEEP_WIDTH;

  state_e                    r_state;
  logic [S_DATA_WIDTH-1:0]   r_hold_data;
  logic [S_KEEP_WIDTH-1:0]   r_hold_keep;
  logic                      r_hold_last;
  logic                      r_rdy_en;
  logic [CNT_WIDTH-1:0]      r_pkt_cnt;
  logic                      r_keep_err;

  logic                      w_skip_hi;
  logic                      w_s_hs;
  logic                      w_m_hs;
  logic                      w_finish;
  logic                      w_keep_bad;
  logic [M_KEEP_WIDTH-1:0]   w_in_keep_lo;
  logic [M_KEEP_WIDTH-1:0]   w_in_keep_hi;

  assign w_skip_hi = r_hold_last & (r_hold_keep[S_KEEP_WIDTH-1:M_KEEP_WIDTH] == '0);

  assign m_axis_tvalid = (r_state != ST_EMPTY);
  assign m_axis_tdata  = (r_state == ST_HI) ? r_hold_data[S_DATA_WIDTH-1:M_DATA_WIDTH]
                                            : r_hold_data[M_DATA_WIDTH-1:0];
  assign m_axis_tkeep  = (r_state == ST_HI) ? r_hold_keep[S_KEEP_WIDTH-1:M_KEEP_WIDTH]
                                            : r_hold_keep[M_KEEP_WIDTH-1:0];
  assign m_axis_tlast  = (r_state == ST_HI) ? r_hold_last
                                            : ((r_state == ST_LO) & w_skip_hi);

  // The beat being presented is the final one of the held word, so the slot
  // frees up in the same cycle it is taken downstream.
  assign w_finish = m_axis_tready &
                    ((r_state == ST_HI) | ((r_state == ST_LO) & w_skip_hi));

  assign s_axis_tready = r_rdy_en & ((r_state == ST_EMPTY) | w_finish);

  assign w_s_hs = s_axis_tvalid & s_axis_tready;
  assign w_m_hs = m_axis_tvalid & m_axis_tready;

  assign w_in_keep_lo = s_axis_tkeep[M_KEEP_WIDTH-1:0];
  assign w_in_keep_hi = s_axis_tkeep[S_KEEP_WIDTH-1:M_KEEP_WIDTH];
  assign w_keep_bad   = ((w_in_keep_hi != '0) && (w_in_keep_lo != '1)) ||
                        !keep_contig(64'(w_in_keep_lo)) ||
                        !keep_contig(64'(w_in_keep_hi));

  // NOTE: sequential state is assigned with non-blocking (<=) so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state     <= ST_EMPTY;
      // NOTE: the hold register is reset (not just its valid state) because
      // m_axis_tdata/tkeep are driven straight from it and must read 0 in reset.
      r_hold_data <= '0;
      r_hold_keep <= '0;
      r_hold_last <= 1'b0;
      r_rdy_en    <= 1'b0;
      r_pkt_cnt   <= '0;
      r_keep_err  <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;

      if (w_s_hs) begin
        r_hold_data <= s_axis_tdata;
        r_hold_keep <= s_axis_tkeep;
        r_hold_last <= s_axis_tlast;
        r_state     <= ST_LO;
      end else if (w_finish) begin
        r_state <= ST_EMPTY;
      end else if ((r_state == ST_LO) && m_axis_tready) begin
        r_state <= ST_HI;
      end

      if (w_m_hs && m_axis_tlast) begin
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end

      if (w_s_hs && w_keep_bad) begin
        r_keep_err <= 1'b1;
      end
    end
  end

  assign pkt_cnt  = r_pkt_cnt;
  assign keep_err = r_keep_err;

endmodule
